// File: rtl/instr_aligner_pkg.sv
// Shared types and helpers for the fetch-side instruction aligner.
// The RVC path is compiled in only when INSTR_ALIGNER_RVC_EN is defined.
package fetch_pkg;

    typedef enum logic [1:0] {
        ALIGNED   = 2'd0,
        HALF      = 2'd1,
        SKIP_HALF = 2'd2
    } align_state_e;

    localparam int ILEN = 32;
    localparam int HLEN = 16;

    // A halfword starts a 16-bit RVC encoding unless its low two bits are 2'b11.
    function automatic logic is_rvc(input logic [1:0] op);
        return op != 2'b11;
    endfunction

endpackage

// File: rtl/instr_aligner_if.sv
// FIFO read port plus decode-side valid/ready bundle for instr_aligner.
// The master modport is the aligner; the slave modport is the FIFO and decode side.
interface instr_aligner_if import fetch_pkg::*; #(
    parameter int XLEN = 32
);
    logic            fifo_empty;
    logic [ILEN-1:0] fifo_head;
    logic            fifo_rd_en;
    logic            fifo_clear;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;
    logic            instr_is_compressed;

    modport master (
        input  fifo_empty, fifo_head, instr_ready,
        output fifo_rd_en, fifo_clear, instr_valid, instr_data, instr_pc, instr_is_compressed
    );

    modport slave (
        output fifo_empty, fifo_head, instr_ready,
        input  fifo_rd_en, fifo_clear, instr_valid, instr_data, instr_pc, instr_is_compressed
    );
endinterface

// File: rtl/instr_aligner_out_stage.sv
// Valid/ready register stage carrying instruction, PC and compressed flag to decode.
// A synchronous clear drops the held instruction on a redirect.
module instr_out_stage import fetch_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic            i_valid,
    input  logic [ILEN-1:0] i_data,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_is_c,
    output logic            o_valid,
    output logic [ILEN-1:0] o_data,
    output logic [XLEN-1:0] o_pc,
    output logic            o_is_c
);
    logic            r_valid;
    logic [ILEN-1:0] r_data;
    logic [XLEN-1:0] r_pc;
    logic            r_is_c;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
            r_is_c  <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_pc   <= i_pc;
                r_is_c <= i_is_c;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
    assign o_is_c  = r_is_c;
endmodule

// File: rtl/instr_aligner.sv
// Re-cuts 32-bit fetch words into RV32 instructions and owns the FIFO flush on redirect.
// Define INSTR_ALIGNER_RVC_EN to enable 16-bit compressed support and halfword alignment.
module instr_aligner import fetch_pkg::*; #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    instr_aligner_if.master bus
);
    logic            w_redirect;
    logic            w_adv;
    logic            w_pop;
    logic            w_emit;
    logic [ILEN-1:0] w_data;
    logic            w_is_c;
    logic            w_out_valid;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] r_next_pc;

    // Reset masks the combinational FIFO controls so nothing is popped or flushed in reset.
    assign w_redirect     = i_redirect & reset_n;
    assign w_adv          = !w_out_valid | bus.instr_ready;
    assign bus.fifo_clear = w_redirect;
    assign bus.fifo_rd_en = w_pop & reset_n;

`ifdef INSTR_ALIGNER_RVC_EN
    align_state_e    r_state;
    align_state_e    w_state_nxt;
    logic [HLEN-1:0] r_res;
    logic [HLEN-1:0] w_res_nxt;

    assign w_redirect_pc = i_redirect_pc;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_pop       = 1'b0;
        w_emit      = 1'b0;
        w_data      = bus.fifo_head;
        w_is_c      = 1'b0;
        w_state_nxt = r_state;
        w_res_nxt   = r_res;
        if (w_adv && !w_redirect) begin
            unique case (r_state)
                ALIGNED: if (!bus.fifo_empty) begin
                    w_pop  = 1'b1;
                    w_emit = 1'b1;
                    if (is_rvc(bus.fifo_head[1:0])) begin
                        w_data      = {16'h0000, bus.fifo_head[15:0]};
                        w_is_c      = 1'b1;
                        w_res_nxt   = bus.fifo_head[31:16];
                        w_state_nxt = HALF;
                    end
                end
                HALF: if (is_rvc(r_res[1:0])) begin
                    w_emit      = 1'b1;
                    w_data      = {16'h0000, r_res};
                    w_is_c      = 1'b1;
                    w_state_nxt = ALIGNED;
                end else if (!bus.fifo_empty) begin
                    w_pop     = 1'b1;
                    w_emit    = 1'b1;
                    w_data    = {bus.fifo_head[15:0], r_res};
                    w_res_nxt = bus.fifo_head[31:16];
                end
                SKIP_HALF: if (!bus.fifo_empty) begin
                    w_pop = 1'b1;
                    // Upper half either is a whole RVC instr or starts a straddling 32-bit one.
                    if (is_rvc(bus.fifo_head[17:16])) begin
                        w_emit      = 1'b1;
                        w_data      = {16'h0000, bus.fifo_head[31:16]};
                        w_is_c      = 1'b1;
                        w_state_nxt = ALIGNED;
                    end else begin
                        w_res_nxt   = bus.fifo_head[31:16];
                        w_state_nxt = HALF;
                    end
                end
                default: w_state_nxt = ALIGNED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ALIGNED;
            r_res   <= '0;
        end else if (w_redirect) begin
            r_state <= i_redirect_pc[1] ? SKIP_HALF : ALIGNED;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_res   <= w_res_nxt;
        end
    end
`else
    // Without RVC every fetch word is one 32-bit instruction on a word boundary.
    assign w_redirect_pc = i_redirect_pc & ~XLEN'(2);
    assign w_pop         = w_adv & !w_redirect & !bus.fifo_empty;
    assign w_emit        = w_pop;
    assign w_data        = bus.fifo_head;
    assign w_is_c        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_next_pc <= RESET_PC;
        else if (w_redirect) r_next_pc <= w_redirect_pc;
        else if (w_emit)     r_next_pc <= r_next_pc + (w_is_c ? XLEN'(2) : XLEN'(4));
    end

    instr_out_stage #(.XLEN(XLEN)) u_out_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_redirect),
        .i_load  (w_adv),
        .i_valid (w_emit),
        .i_data  (w_data),
        .i_pc    (r_next_pc),
        .i_is_c  (w_is_c),
        .o_valid (w_out_valid),
        .o_data  (bus.instr_data),
        .o_pc    (bus.instr_pc),
        .o_is_c  (bus.instr_is_compressed)
    );

    assign bus.instr_valid = w_out_valid;
endmodule

// File: tb/tb_instr_aligner.sv
// Directed bench for instr_aligner with a small FIFO model and hand-computed expectations.
// RVC-specific vectors are selected with INSTR_ALIGNER_RVC_EN, matching the RTL build.
`timescale 1ns/1ps
module tb_instr_aligner;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    always #5 clk = ~clk;

    instr_aligner_if #(.XLEN(32)) bus ();

    instr_aligner #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .bus           (bus)
    );

    logic [31:0] fmem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int clr_cnt = 0;
    int pop_empty_cnt = 0;
    int n_checks = 0;
    int n_pass = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_head  = fmem[rd_ptr[3:0]];

    // FIFO model: flush wins over pop; a pop of an empty FIFO is recorded as an error.
    always @(posedge clk) begin
        if (bus.fifo_clear) begin
            rd_ptr  <= wr_ptr;
            clr_cnt <= clr_cnt + 1;
        end else if (bus.fifo_rd_en) begin
            pop_cnt <= pop_cnt + 1;
            if (rd_ptr == wr_ptr) pop_empty_cnt <= pop_empty_cnt + 1;
            else                  rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        fmem[wr_ptr[3:0]] = w;
        wr_ptr++;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                              input logic [31:0] pc, input logic c);
        check({tag, "_valid"}, 64'(bus.instr_valid), 64'(v));
        if (v) begin
            check({tag, "_data"}, 64'(bus.instr_data), 64'(d));
            check({tag, "_pc"}, 64'(bus.instr_pc), 64'(pc));
            check({tag, "_isc"}, 64'(bus.instr_is_compressed), 64'(c));
        end
    endtask

    // Pulse redirect for one cycle starting at a negedge; returns at the following negedge.
    task automatic do_redirect(input logic [31:0] pc);
        int c0;
        c0 = clr_cnt;
        redirect    = 1'b1;
        redirect_pc = pc;
        #1;
        check("redir_clear", 64'(bus.fifo_clear), 64'd1);
        check("redir_no_pop", 64'(bus.fifo_rd_en), 64'd0);
        tick();
        redirect = 1'b0;
        check("redir_clear_once", 64'(clr_cnt - c0), 64'd1);
        check("redir_valid_drop", 64'(bus.instr_valid), 64'd0);
    endtask

    initial begin
        int p0;
        bus.instr_ready = 1'b1;

        // Reset state, with a non-empty FIFO and a redirect that must be ignored.
        push(32'h0000_0013);
        push(32'h0010_0093);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        check("rst_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_data", 64'(bus.instr_data), 64'd0);
        check("rst_pc", 64'(bus.instr_pc), 64'd0);
        check("rst_isc", 64'(bus.instr_is_compressed), 64'd0);
        check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("rst_clear", 64'(bus.fifo_clear), 64'd0);
        redirect = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("a_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        tick();
        expect_out("a0", 1'b1, 32'h0000_0013, 32'h0, 1'b0);
        check("a_rd_en2", 64'(bus.fifo_rd_en), 64'd1);
        tick();
        expect_out("a1", 1'b1, 32'h0010_0093, 32'h4, 1'b0);
        tick();
        expect_out("a_idle", 1'b0, 32'h0, 32'h0, 1'b0);
        check("a_pops", 64'(pop_cnt), 64'd2);

        // 0x00814505: two RVC halves from one pop, or one 32-bit word without RVC.
        do_redirect(32'h0);
        p0 = pop_cnt;
        push(32'h0081_4505);
        #1;
        check("b_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        tick();
`ifdef INSTR_ALIGNER_RVC_EN
        expect_out("b0", 1'b1, 32'h0000_4505, 32'h0, 1'b1);
        check("b_no_pop_empty", 64'(bus.fifo_rd_en), 64'd0);
        tick();
        expect_out("b1", 1'b1, 32'h0000_0081, 32'h2, 1'b1);
        tick();
        expect_out("b_idle", 1'b0, 32'h0, 32'h0, 1'b0);
        check("b_pops", 64'(pop_cnt - p0), 64'd1);

        // Straddling 32-bit instruction, then a zero residue emitted as RVC with FIFO empty.
        do_redirect(32'h0);
        push(32'h0013_4501);
        push(32'h0000_0093);
        tick();
        expect_out("c0", 1'b1, 32'h0000_4501, 32'h0, 1'b1);
        check("c_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        tick();
        expect_out("c1", 1'b1, 32'h0093_0013, 32'h2, 1'b0);
        check("c_no_pop", 64'(bus.fifo_rd_en), 64'd0);
        tick();
        expect_out("c2", 1'b1, 32'h0000_0000, 32'h6, 1'b1);
        tick();
        expect_out("c_idle", 1'b0, 32'h0, 32'h0, 1'b0);

        // Odd-halfword target whose upper half starts a 32-bit instruction.
        do_redirect(32'h202);
        push(32'h0093_1234);
        push(32'h5678_0013);
        tick();
        expect_out("s_none", 1'b0, 32'h0, 32'h0, 1'b0);
        check("s_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        tick();
        expect_out("s0", 1'b1, 32'h0013_0093, 32'h202, 1'b0);
        tick();
        expect_out("s1", 1'b1, 32'h0000_5678, 32'h206, 1'b1);
        tick();
`else
        expect_out("b0", 1'b1, 32'h0081_4505, 32'h0, 1'b0);
        push(32'h0000_0013);
        tick();
        expect_out("b1", 1'b1, 32'h0000_0013, 32'h4, 1'b0);
        tick();
        expect_out("b_idle", 1'b0, 32'h0, 32'h0, 1'b0);
        check("b_pops", 64'(pop_cnt - p0), 64'd2);
`endif

        // Redirect to 0x106 with head 0x4505FFFF.
        do_redirect(32'h106);
        push(32'h4505_FFFF);
        #1;
        check("d_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        tick();
`ifdef INSTR_ALIGNER_RVC_EN
        expect_out("d0", 1'b1, 32'h0000_4505, 32'h106, 1'b1);
`else
        expect_out("d0", 1'b1, 32'h4505_FFFF, 32'h104, 1'b0);
`endif
        push(32'h0000_0013);
        tick();
        expect_out("d1", 1'b1, 32'h0000_0013, 32'h108, 1'b0);
        tick();

        // PC wraps modulo 2^32.
        do_redirect(32'hFFFF_FFFC);
        push(32'h0000_0013);
        push(32'h0000_0093);
        tick();
        expect_out("w0", 1'b1, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0);
        tick();
        expect_out("w1", 1'b1, 32'h0000_0093, 32'h0, 1'b0);
        tick();

        // Five-cycle stall holds outputs and blocks pops; a redirect drops the held instr.
        do_redirect(32'h40);
        p0 = pop_cnt;
        push(32'h1111_1113);
        push(32'h2222_2213);
        push(32'h3333_3313);
        push(32'h4444_4413);
        tick();
        expect_out("e0", 1'b1, 32'h1111_1113, 32'h40, 1'b0);
        bus.instr_ready = 1'b0;
        #1;
        check("e_stall_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("e_hold", 1'b1, 32'h1111_1113, 32'h40, 1'b0);
        end
        check("e_stall_pops", 64'(pop_cnt - p0), 64'd1);
        bus.instr_ready = 1'b1;
        tick();
        expect_out("e1", 1'b1, 32'h2222_2213, 32'h44, 1'b0);
        tick();
        expect_out("e2", 1'b1, 32'h3333_3313, 32'h48, 1'b0);
        bus.instr_ready = 1'b0;
        tick();
        expect_out("e2_hold", 1'b1, 32'h3333_3313, 32'h48, 1'b0);
        do_redirect(32'h80);
        bus.instr_ready = 1'b1;
        tick();
        expect_out("e_flushed", 1'b0, 32'h0, 32'h0, 1'b0);
        check("e_pops", 64'(pop_cnt - p0), 64'd3);

        // Asynchronous reset mid-operation, then restart from RESET_PC.
        do_redirect(32'h300);
        push(32'h1111_1113);
        push(32'h2222_2213);
        tick();
        expect_out("f0", 1'b1, 32'h1111_1113, 32'h300, 1'b0);
        bus.instr_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("f_rst_valid", 64'(bus.instr_valid), 64'd0);
        check("f_rst_data", 64'(bus.instr_data), 64'd0);
        check("f_rst_pc", 64'(bus.instr_pc), 64'd0);
        check("f_rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        tick();
        reset_n = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        expect_out("f1", 1'b1, 32'h2222_2213, 32'h0, 1'b0);

        check("no_pop_when_empty", 64'(pop_empty_cnt), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
